// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    localparam int N     = 8;                // length of x and h
    localparam int W     = 4;                // sample / coefficient / result width
    localparam int YLEN  = 2 * N - 1;        // number of outputs y[0..2N-2]
    localparam int IDXW  = $clog2(N);        // width of x/h index (load_idx, k)
    localparam int YIDXW = $clog2(YLEN);     // width of output index (y_idx, n)

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/conv_if.sv
// Control, load and result bus between a host and conv_controller.
// Latency: n/a (wires only).
// Backpressure: y_valid/y_ready handshake on the result side; load and start have none.
//
// Ports: start, load_valid/load_sel/load_idx/load_data (host -> block),
//        busy, y_valid/y_idx/y_data, done (block -> host), y_ready (host -> block).
interface conv_if #(
    parameter int N = conv_pkg::N,
    parameter int W = conv_pkg::W
);
    import conv_pkg::*;

    localparam int XIW = $clog2(N);
    localparam int YIW = $clog2(2 * N - 1);

    logic           start;
    logic           load_valid;
    logic           load_sel;
    logic [XIW-1:0] load_idx;
    logic [W-1:0]   load_data;
    logic           busy;
    logic           y_valid;
    logic           y_ready;
    logic [YIW-1:0] y_idx;
    logic [W-1:0]   y_data;
    logic           done;

    // Host side
    modport master (
        output start, load_valid, load_sel, load_idx, load_data, y_ready,
        input  busy, y_valid, y_idx, y_data, done
    );

    // Controller side
    modport slave (
        input  start, load_valid, load_sel, load_idx, load_data, y_ready,
        output busy, y_valid, y_idx, y_data, done
    );

endinterface

// File: rtl/conv_mac.sv
// W-bit multiply-accumulate, product and sum both wrap modulo 2^W.
// Latency: 1 cycle (acc reflects a*b on the edge where en is high).
// Backpressure: none; accumulates only when en is high, holds otherwise.
//
// Ports: clk, rst (async high), en (accumulate this cycle), clr (start from 0
//        instead of acc), a/b (operands), acc (registered running sum).
module conv_mac #(
    parameter int W = conv_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] acc
);
    import conv_pkg::*;

    logic [W-1:0] prod;
    logic [W-1:0] base;

    // Self-determined W-bit multiply: upper product bits are discarded on purpose.
    assign prod = W'(a * b);
    assign base = clr ? '0 : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + prod;
        end
    end

endmodule

// File: rtl/conv_controller.sv
// Sequential full convolution y[n] = sum x[k]*h[n-k] over two N-entry register files.
// Latency: first y_valid N+1 cycles after start; N idle cycles between outputs.
// Backpressure: y_valid/y_idx/y_data held until y_ready; computation of the next n waits.
//
// Ports: clk, rst (async high), bus (conv_if.slave: start, load_*, busy,
//        y_valid/y_ready/y_idx/y_data, done).
module conv_controller #(
    parameter int N = conv_pkg::N,
    parameter int W = conv_pkg::W
) (
    input  logic   clk,
    input  logic   rst,
    conv_if.slave  bus
);
    import conv_pkg::*;

    localparam int XIW = $clog2(N);
    localparam int YIW = $clog2(2 * N - 1);

    state_t         state, state_nx;
    logic [W-1:0]   xmem [N];
    logic [W-1:0]   hmem [N];
    logic [YIW-1:0] n;
    logic [XIW-1:0] k;
    logic [W-1:0]   acc;

    logic           idle;
    logic           last_k;
    logic           last_n;
    logic [YIW:0]   diff;
    logic           term_ok;
    logic [XIW-1:0] hidx;
    logic [W-1:0]   mac_b;

    assign idle   = (state == IDLE);
    assign last_k = (k == XIW'(N - 1));
    assign last_n = (n == YIW'(2 * N - 2));

    // n-k with one extra bit so a negative difference shows up as the top bit.
    assign diff    = {1'b0, n} - (YIW + 1)'(k);
    assign term_ok = !diff[YIW] && (diff < (YIW + 1)'(N));
    assign hidx    = diff[XIW-1:0];
    assign mac_b   = term_ok ? hmem[hidx] : '0;

    conv_mac #(.W(W)) u_mac (
        .clk (clk),
        .rst (rst),
        .en  (state == COMPUTE),
        .clr (k == '0),
        .a   (xmem[k]),
        .b   (mac_b),
        .acc (acc)
    );

    // Memories are only writable in IDLE, so a write alongside start lands
    // before the first COMPUTE cycle reads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                xmem[i] <= '0;
                hmem[i] <= '0;
            end
        end else if (idle && bus.load_valid) begin
            if (bus.load_sel) begin
                hmem[bus.load_idx] <= bus.load_data;
            end else begin
                xmem[bus.load_idx] <= bus.load_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= '0;
            k <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n <= '0;
                        k <= '0;
                    end
                end
                COMPUTE: begin
                    k <= last_k ? '0 : k + 1'b1;
                end
                OUTPUT: begin
                    if (bus.y_ready && !last_n) begin
                        n <= n + 1'b1;
                        k <= '0;
                    end
                end
                DONE: begin
                    n <= '0;
                    k <= '0;
                end
                default: begin
                    n <= '0;
                    k <= '0;
                end
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        bus.busy    = 1'b1;
        bus.y_valid = 1'b0;
        bus.y_idx   = '0;
        bus.y_data  = '0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_nx = COMPUTE;
                end
            end
            COMPUTE: begin
                if (last_k) begin
                    state_nx = OUTPUT;
                end
            end
            OUTPUT: begin
                // acc is frozen outside COMPUTE, so the offer is stable under stall.
                bus.y_valid = 1'b1;
                bus.y_idx   = n;
                bus.y_data  = acc;
                if (bus.y_ready) begin
                    state_nx = last_n ? DONE : COMPUTE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
